// File: rtl/adder_tree_pipe.sv
// rtl/adder_tree_pipe.sv - pipelined N-input adder tree with valid/ready flow control
// Signed or unsigned operands; the result is clamped or wrapped to OWIDTH.
module adder_tree_pipe #(
  parameter int NUM_INPUTS = 16,
  parameter int DWIDTH     = 14,
  parameter int OWIDTH     = 18,
  parameter bit SIGNED     = 1'b0,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [NUM_INPUTS*DWIDTH-1:0] i_dat_vector,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [OWIDTH-1:0]            o_sum,
  output logic                         o_ovf
);
  localparam int LEVELS = $clog2(NUM_INPUTS);
  localparam int LAT    = (LEVELS < 1) ? 1 : LEVELS;
  localparam int LEAVES = 1 << LEVELS;
  localparam int FW     = DWIDTH + LEVELS;

  logic [FW-1:0]  leaf [LEAVES];
  logic [FW-1:0]  rg   [LAT][LEAVES];
  logic [LAT-1:0] vld;
  logic           adv;
  logic [FW-1:0]  s;

  assign adv     = ~vld[LAT-1] | i_ready;
  assign o_ready = adv;
  assign o_valid = vld[LAT-1];
  assign s       = rg[LAT-1][0];

  // Leaves beyond NUM_INPUTS stay zero so the tree can be a full binary tree.
  always_comb begin
    for (int k = 0; k < LEAVES; k++) leaf[k] = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (SIGNED) leaf[k] = FW'($signed(i_dat_vector[DWIDTH*k +: DWIDTH]));
      else        leaf[k] = FW'(i_dat_vector[DWIDTH*k +: DWIDTH]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (adv) begin
      vld[0] <= i_valid;
      for (int k = 1; k < LAT; k++) vld[k] <= vld[k-1];
    end
  end

  generate
    if (LEVELS == 0) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   rg[0][0] <= '0;
        else if (adv) rg[0][0] <= leaf[0];
      end
    end else begin : g_tree
      // Stage k holds the node sums of tree level k+1; the last stage holds the full sum.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int st = 0; st < LAT; st++)
            for (int n = 0; n < LEAVES; n++) rg[st][n] <= '0;
        end else if (adv) begin
          for (int n = 0; n < LEAVES/2; n++) rg[0][n] <= leaf[2*n] + leaf[2*n+1];
          for (int st = 1; st < LAT; st++)
            for (int n = 0; n < (LEAVES >> (st+1)); n++)
              rg[st][n] <= rg[st-1][2*n] + rg[st-1][2*n+1];
        end
      end
    end
  endgenerate

  generate
    if (OWIDTH >= FW) begin : g_ext
      always_comb begin
        o_sum = OWIDTH'(s);
        if (SIGNED) o_sum = OWIDTH'($signed(s));
      end
      assign o_ovf = 1'b0;
    end else begin : g_narrow
      logic              fits;
      logic [OWIDTH-1:0] sat_val;
      always_comb begin
        fits    = 1'b0;
        sat_val = '1;
        if (SIGNED) begin
          // In range only if every dropped bit equals the new sign bit.
          fits = (s[FW-1:OWIDTH-1] == '0) || (s[FW-1:OWIDTH-1] == '1);
          if (s[FW-1]) begin
            sat_val             = '0;
            sat_val[OWIDTH-1]   = 1'b1;
          end else begin
            sat_val[OWIDTH-1]   = 1'b0;
          end
        end else begin
          fits = (s[FW-1:OWIDTH] == '0);
        end
        o_sum = (fits || !SATURATE) ? s[OWIDTH-1:0] : sat_val;
        o_ovf = ~fits;
      end
    end
  endgenerate
endmodule
